// File: rtl/stream_framer.sv
// ----------------------------------------------------------------------------
// stream_framer
//   Groups a word stream into packets of a programmable beat count and marks
//   the final beat of each packet with olast. The output is registered and
//   backed by a single skid entry, so one beat per cycle is sustained under
//   backpressure. Completed packets are counted for software/debug.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   len        packet length in beats, sampled at packet start (0 -> 1,
//              values above MAXLEN clamp to MAXLEN)
//   flush      single-cycle request to close the current packet early
//   idata      input word
//   ivalid     input word valid
//   iready     block can accept a word (high iff skid entry is empty)
//   odata      output word
//   ovalid     output word valid
//   olast      final beat of the packet, qualified by ovalid
//   oready     downstream accepts a word
//   pkt_count  packets completed at the output, modulo 2^CNTW
// ----------------------------------------------------------------------------
module stream_framer #(
   parameter int DW     = 32,
   parameter int MAXLEN = 16,
   parameter int LENW   = $clog2(MAXLEN + 1),
   parameter int CNTW   = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LENW-1:0] len,
   input  logic            flush,
   input  logic [DW-1:0]   idata,
   input  logic            ivalid,
   output logic            iready,
   output logic [DW-1:0]   odata,
   output logic            ovalid,
   output logic            olast,
   input  logic            oready,
   output logic [CNTW-1:0] pkt_count
);

   localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);
   localparam logic [LENW-1:0] ONE_L    = LENW'(1);

   typedef enum logic {IDLE, BODY} state_t;

   state_t          state_q;
   logic [LENW-1:0] cnt_q;
   logic [LENW-1:0] plen_q;
   logic            flush_pend_q;

   logic [DW-1:0]   out_data_q;
   logic            out_last_q;
   logic            out_vld_q;
   logic [DW-1:0]   skid_data_q;
   logic            skid_last_q;
   logic            skid_vld_q;
   logic [CNTW-1:0] pkt_cnt_q;

   logic [LENW-1:0] len_clamp;
   logic [LENW-1:0] cnt_inc;
   logic            accept;
   logic            acc_last;
   logic            out_free;

   assign iready    = ~skid_vld_q;
   assign odata     = out_data_q;
   assign ovalid    = out_vld_q;
   assign olast     = out_last_q;
   assign pkt_count = pkt_cnt_q;

   assign accept   = ivalid & ~skid_vld_q;
   // The output register can take a new beat when it is empty or being taken.
   assign out_free = ~out_vld_q | oready;
   assign cnt_inc  = cnt_q + ONE_L;

   // The last flag is decided when a word is accepted, so it travels with the
   // word through the skid entry and output register unchanged.
   always_comb begin
      len_clamp = len;
      if (len == '0) begin
         len_clamp = ONE_L;
      end else if (len > MAXLEN_L) begin
         len_clamp = MAXLEN_L;
      end
      if (state_q == IDLE) begin
         acc_last = (len_clamp == ONE_L) | flush | flush_pend_q;
      end else begin
         acc_last = (cnt_inc == plen_q) | flush | flush_pend_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         plen_q       <= '0;
         flush_pend_q <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_vld_q    <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_vld_q   <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         // Framing FSM
         if (accept) begin
            // A pending flush is consumed by the beat it closes.
            flush_pend_q <= 1'b0;
            case (state_q)
               IDLE: begin
                  plen_q <= len_clamp;
                  if (acc_last) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= ONE_L;
                     state_q <= BODY;
                  end
               end
               BODY: begin
                  if (acc_last) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q   <= cnt_inc;
                  end
               end
               default: begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            endcase
         end else if (flush) begin
            // No beat to close now; repeated pulses collapse into one.
            flush_pend_q <= 1'b1;
         end

         // Output register and skid entry
         if (out_free) begin
            if (skid_vld_q) begin
               out_data_q <= skid_data_q;
               out_last_q <= skid_last_q;
               out_vld_q  <= 1'b1;
               skid_vld_q <= 1'b0;
            end else if (accept) begin
               out_data_q <= idata;
               out_last_q <= acc_last;
               out_vld_q  <= 1'b1;
            end else begin
               out_vld_q  <= 1'b0;
            end
         end else if (accept) begin
            skid_data_q <= idata;
            skid_last_q <= acc_last;
            skid_vld_q  <= 1'b1;
         end

         if (out_vld_q && oready && out_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_framer.sv
// ----------------------------------------------------------------------------
// tb_stream_framer
//   Directed bench for stream_framer. A second instance with a 2-bit packet
//   counter shares all inputs to observe counter wrap.
// ----------------------------------------------------------------------------
module tb_stream_framer;

   localparam int DW     = 32;
   localparam int MAXLEN = 16;
   localparam int LENW   = $clog2(MAXLEN + 1);
   localparam int CNTW   = 16;

   logic            clk;
   logic            rst;
   logic [LENW-1:0] len;
   logic            flush;
   logic [DW-1:0]   idata;
   logic            ivalid;
   logic            iready;
   logic [DW-1:0]   odata;
   logic            ovalid;
   logic            olast;
   logic            oready;
   logic [CNTW-1:0] pkt_count;

   logic            iready2;
   logic [DW-1:0]   odata2;
   logic            ovalid2;
   logic            olast2;
   logic [1:0]      pkt_count2;

   logic            oready_man;
   logic            bp_en;
   logic            pat_bit;

   int total;
   int bad;

   logic [DW-1:0] got_d[$];
   logic          got_l[$];
   logic          ir_drop;
   logic          hold_prev;
   logic [DW-1:0] prev_d;
   logic          prev_l;

   assign oready = bp_en ? pat_bit : oready_man;

   stream_framer #(.DW(DW), .MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .len(len), .flush(flush), .idata(idata),
      .ivalid(ivalid), .iready(iready), .odata(odata), .ovalid(ovalid),
      .olast(olast), .oready(oready), .pkt_count(pkt_count)
   );

   stream_framer #(.DW(DW), .MAXLEN(MAXLEN), .LENW(LENW), .CNTW(2)) dut2 (
      .clk(clk), .rst(rst), .len(len), .flush(flush), .idata(idata),
      .ivalid(ivalid), .iready(iready2), .odata(odata2), .ovalid(ovalid2),
      .olast(olast2), .oready(oready), .pkt_count(pkt_count2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // oready pattern 1,0,0,1,1,0 when backpressure is enabled
   initial begin
      logic [5:0] pat;
      int pidx;
      pat     = 6'b011001;   // bit0 first
      pidx    = 0;
      pat_bit = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            pat_bit = pat[pidx];
            pidx    = (pidx + 1) % 6;
         end
      end
   end

   // Output monitor: records transfers and checks hold stability.
   initial begin
      hold_prev = 1'b0;
      prev_d    = '0;
      prev_l    = 1'b0;
      ir_drop   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && hold_prev) begin
            check("hold_vld", 64'(ovalid), 64'(1));
            check("hold_data", 64'(odata), 64'(prev_d));
            check("hold_last", 64'(olast), 64'(prev_l));
         end
         if (rst && ovalid && oready) begin
            got_d.push_back(odata);
            got_l.push_back(olast);
         end
         if (!iready) ir_drop = 1'b1;
         hold_prev = rst && ovalid && !oready;
         prev_d    = odata;
         prev_l    = olast;
      end
   end

   task automatic do_reset();
      rst    = 1'b0;
      ivalid = 1'b0;
      flush  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      got_d.delete();
      got_l.delete();
      ir_drop = 1'b0;
   endtask

   // Present one word (optionally with flush) and hold it until accepted.
   task automatic push(input logic [DW-1:0] d, input logic fl);
      logic acc;
      acc    = 1'b0;
      ivalid = 1'b1;
      idata  = d;
      flush  = fl;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = iready;
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
      check("push_acc", 64'(acc), 64'(1));
   endtask

   task automatic stop_in();
      ivalid = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic flush_pulse();
      ivalid = 1'b0;
      flush  = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int k;
      k = 0;
      while (got_d.size() < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("beat_count", 64'(got_d.size()), 64'(n));
   endtask

   task automatic check_frame(input string nm, input int n, input logic [DW-1:0] base,
                              input logic [63:0] lastmask);
      for (int i = 0; i < n && i < got_d.size(); i++) begin
         check($sformatf("%s_data%0d", nm, i), 64'(got_d[i]), 64'(base + DW'(i)));
         check($sformatf("%s_last%0d", nm, i), 64'(got_l[i]), 64'(lastmask[i]));
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      bp_en      = 1'b0;
      oready_man = 1'b1;
      len        = LENW'(4);
      flush      = 1'b0;
      ivalid     = 1'b0;
      idata      = '0;
      rst        = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      // Reset values
      check("rst_ovalid", 64'(ovalid), 64'(0));
      check("rst_olast", 64'(olast), 64'(0));
      check("rst_odata", 64'(odata), 64'(0));
      check("rst_iready", 64'(iready), 64'(1));
      check("rst_pkt", 64'(pkt_count), 64'(0));
      check("rst_pkt2", 64'(pkt_count2), 64'(0));
      do_reset();

      // Basic framing: len=4, 12 words back to back
      len = LENW'(4);
      push(32'd0, 1'b0);
      check("lat_ovalid", 64'(ovalid), 64'(1));
      check("lat_odata", 64'(odata), 64'(0));
      for (int i = 1; i < 12; i++) push(DW'(i), 1'b0);
      stop_in();
      wait_out(12);
      check_frame("basic", 12, 32'd0, 64'h888);
      check("basic_pkt", 64'(pkt_count), 64'(3));
      check("basic_pkt2", 64'(pkt_count2), 64'(3));
      check("basic_iready", 64'(ir_drop), 64'(0));

      // Backpressure through the skid entry: len=3
      do_reset();
      len   = LENW'(3);
      bp_en = 1'b1;
      for (int i = 0; i < 12; i++) push(32'h100 + DW'(i), 1'b0);
      stop_in();
      wait_out(12);
      bp_en = 1'b0;
      check_frame("skid", 12, 32'h100, 64'h924);
      check("skid_pkt", 64'(pkt_count), 64'(4));
      check("skid_irdrop", 64'(ir_drop), 64'(1));

      // len=0 behaves as len=1
      do_reset();
      len = LENW'(0);
      for (int i = 0; i < 3; i++) push(32'h200 + DW'(i), 1'b0);
      stop_in();
      wait_out(3);
      check_frame("len0", 3, 32'h200, 64'h7);
      check("len0_pkt", 64'(pkt_count), 64'(3));

      // len above MAXLEN clamps to 16 beats
      do_reset();
      len = LENW'(MAXLEN + 5);
      for (int i = 0; i < 32; i++) push(32'h300 + DW'(i), 1'b0);
      stop_in();
      wait_out(32);
      check_frame("lenmax", 32, 32'h300, 64'h8000_8000);
      check("lenmax_pkt", 64'(pkt_count), 64'(2));

      // Flush: idle flush, natural-last flush, repeated flush pulses
      do_reset();
      len = LENW'(8);
      for (int i = 0; i < 3; i++) push(32'h400 + DW'(i), 1'b0);
      stop_in();
      flush_pulse();
      repeat (5) @(posedge clk);
      #1;
      push(32'h403, 1'b0);
      for (int i = 4; i < 19; i++) push(32'h400 + DW'(i), 1'b0);
      push(32'h413, 1'b1);
      for (int i = 20; i < 28; i++) push(32'h400 + DW'(i), 1'b0);
      stop_in();
      flush_pulse();
      @(posedge clk);
      #1;
      flush_pulse();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 28; i < 37; i++) push(32'h400 + DW'(i), 1'b0);
      stop_in();
      wait_out(37);
      check_frame("flush", 37, 32'h400, 64'h10_1808_0808);
      check("flush_pkt", 64'(pkt_count), 64'(6));

      // Counter wrap on the 2-bit instance: 5 single-beat packets
      do_reset();
      len = LENW'(1);
      for (int i = 0; i < 5; i++) push(32'h500 + DW'(i), 1'b0);
      stop_in();
      wait_out(5);
      check_frame("wrap", 5, 32'h500, 64'h1F);
      check("wrap_pkt", 64'(pkt_count), 64'(5));
      check("wrap_pkt2", 64'(pkt_count2), 64'(1));

      // len change during the 2nd beat takes effect on the next packet
      do_reset();
      len = LENW'(4);
      push(32'h600, 1'b0);
      len = LENW'(2);
      for (int i = 1; i < 6; i++) push(32'h600 + DW'(i), 1'b0);
      stop_in();
      wait_out(6);
      check_frame("midlen", 6, 32'h600, 64'h28);
      check("midlen_pkt", 64'(pkt_count), 64'(2));

      // Asynchronous reset with output and skid both holding beats
      do_reset();
      len = LENW'(1);
      push(32'h700, 1'b0);
      stop_in();
      wait_out(1);
      check("ar_pre_pkt", 64'(pkt_count), 64'(1));
      oready_man = 1'b0;
      push(32'h701, 1'b0);
      push(32'h702, 1'b0);
      stop_in();
      check("ar_pre_ovalid", 64'(ovalid), 64'(1));
      check("ar_pre_olast", 64'(olast), 64'(1));
      check("ar_pre_iready", 64'(iready), 64'(0));
      #2;
      rst = 1'b0;
      #1;
      check("ar_ovalid", 64'(ovalid), 64'(0));
      check("ar_olast", 64'(olast), 64'(0));
      check("ar_odata", 64'(odata), 64'(0));
      check("ar_pkt", 64'(pkt_count), 64'(0));
      check("ar_pkt2", 64'(pkt_count2), 64'(0));
      check("ar_iready", 64'(iready), 64'(1));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      got_d.delete();
      got_l.delete();
      oready_man = 1'b1;
      len = LENW'(4);
      for (int i = 0; i < 4; i++) push(32'h800 + DW'(i), 1'b0);
      stop_in();
      wait_out(4);
      check_frame("postrst", 4, 32'h800, 64'h8);
      check("postrst_pkt", 64'(pkt_count), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
